// File: rtl/cla_pkg.sv
// Shared types and constants for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

    localparam int unsigned GROUP_W = 4;

    // Group propagate/generate pair produced by each 4-bit lookahead group
    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Number of 4-bit lookahead groups in a WIDTH-bit operand
    function automatic int unsigned group_count(input int unsigned width);
        return width / GROUP_W;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: sum with carry-in plus group propagate/generate.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output pg_t                pg
);

    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] c;

    // Bit-level lookahead carries and group P/G, all flattened two-level logic
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        sum  = p ^ c;
        pg.p = &p;
        pg.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 registers group P/G, carry-in-0 group sums and the carry-in; stage 2
// resolves group carries by lookahead and registers sum and flags.
// Optional macro PIPELINED_CLA_SAT_EN clamps the sum to signed max/min on overflow.
module pipelined_cla_addsub
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NG = group_count(WIDTH);

    if ((WIDTH % GROUP_W) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_width
        $error("pipelined_cla_addsub: WIDTH must be a multiple of 4 between 8 and 64");
    end

    logic [WIDTH-1:0] bb;
    pg_t  [NG-1:0]    pg_w;
    logic [WIDTH-1:0] sum0_w;

    logic             s1_valid;
    pg_t  [NG-1:0]    s1_pg;
    logic [WIDTH-1:0] s1_sum;
    logic             s1_cin;
    logic             s1_pmsb;

    logic             s1_adv;
    logic             s2_adv;
    logic [NG:0]      gc;
    logic [WIDTH-1:0] sum_raw;
    logic [WIDTH-1:0] sum_next;
    logic             cout_next;
    logic             ovf_next;
    logic             zero_next;

    // Operand B is inverted for subtraction; the +1 enters as the group-0 carry-in in stage 2
    always_comb begin
        bb = sub ? ~b : b;
    end

    // Stage-1 groups evaluate with carry-in 0; the real group carry is added in stage 2
    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group4 u_grp (
            .a   (a[k*GROUP_W +: GROUP_W]),
            .b   (bb[k*GROUP_W +: GROUP_W]),
            .cin (1'b0),
            .sum (sum0_w[k*GROUP_W +: GROUP_W]),
            .pg  (pg_w[k])
        );
    end

    // Stage 2 advances when empty or draining; stage 1 when empty or stage 2 advances
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = !s1_valid || !out_valid || out_ready;
        in_ready = !rst && s1_adv;
    end

    // Group-level lookahead over registered P/G, then fold each group carry into its sum
    assign gc[0] = s1_cin;
    for (genvar k = 0; k < NG; k++) begin : g_carry
        assign gc[k+1] = s1_pg[k].g | (s1_pg[k].p & gc[k]);
        assign sum_raw[k*GROUP_W +: GROUP_W] = s1_sum[k*GROUP_W +: GROUP_W] + GROUP_W'(gc[k]);
    end

    // Carry into the MSB is recovered from the MSB sum bit and its half-sum
    assign cout_next = gc[NG];
    assign ovf_next  = (sum_raw[WIDTH-1] ^ s1_pmsb) ^ gc[NG];

    // Final sum (optionally saturated) and zero flag taken from that final value
    always_comb begin
        sum_next = sum_raw;
`ifdef PIPELINED_CLA_SAT_EN
        if (ovf_next) begin
            sum_next = sum_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        end
`endif
        zero_next = (sum_next == '0);
    end

    // Pipeline registers; both stages may advance in the same cycle on a full pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_pg     <= '0;
            s1_sum    <= '0;
            s1_cin    <= 1'b0;
            s1_pmsb   <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_pg   <= pg_w;
                    s1_sum  <= sum0_w;
                    s1_cin  <= sub;
                    s1_pmsb <= a[WIDTH-1] ^ bb[WIDTH-1];
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    sum  <= sum_next;
                    cout <= cout_next;
                    ovf  <= ovf_next;
                    zero <= zero_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub at WIDTH=16.
module tb_pipelined_cla_addsub;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    always #5 clk = ~clk;

    pipelined_cla_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {sum, cout, ovf, zero}
    typedef logic [W+2:0] res_t;
    res_t q[$];

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W-1:0] yy;
        logic [W:0]   f;
        logic [W-1:0] r;
        logic         o;
        yy = s ? ~y : y;
        f  = {1'b0, x} + {1'b0, yy} + 17'(s);
        r  = f[W-1:0];
        o  = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
`ifdef PIPELINED_CLA_SAT_EN
        if (o) r = x[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        return {r, f[W], o, (r == 16'h0000)};
    endfunction

    res_t held;
    logic hold_v = 1'b0;
    int   n_out  = 0;

    // Monitor: handshakes seen here complete on the following rising edge
    always @(negedge clk) begin
        res_t cur;
        res_t e;
        cur = {sum, cout, ovf, zero};
        check_eq("in_ready", 64'(in_ready), 64'(!rst && (q.size() < 2 || out_ready)));
        if (rst) begin
            q.delete();
        end else begin
            if (hold_v) check_eq("hold", {out_valid, cur}, {1'b1, held});
            if (q.size() == 0) check_eq("idle_valid", 64'(out_valid), 64'(0));
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                check_eq("result", cur, e);
                n_out++;
            end
            if (in_valid && in_ready) q.push_back(model(a, b, sub));
        end
        hold_v = !rst && out_valid && !out_ready;
        held   = cur;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1 time unit after a rising edge; returns likewise after the accepting edge
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic ok;
        a = x; b = y; sub = s; in_valid = 1'b1; ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check_eq("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic directed(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic s, input logic [W-1:0] es, input logic ec,
                            input logic eo, input logic ez);
        send(x, y, s);
        @(negedge clk);
        check_eq({tag, "_lat1"}, 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq({tag, "_valid"}, 64'(out_valid), 64'(1));
        check_eq({tag, "_sum"},   64'(sum),  64'(es));
        check_eq({tag, "_cout"},  64'(cout), 64'(ec));
        check_eq({tag, "_ovf"},   64'(ovf),  64'(eo));
        check_eq({tag, "_zero"},  64'(zero), 64'(ez));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] sat_pos;
        logic [W-1:0] sat_neg;
        int           sent;
        int           out_base;
        logic         fell;
        int           acc;

`ifdef PIPELINED_CLA_SAT_EN
        sat_pos = 16'h7FFF;
        sat_neg = 16'h8000;
`else
        sat_pos = 16'h8000;
        sat_neg = 16'h7FFF;
`endif

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_valid", 64'(out_valid), 64'(0));
        check_eq("rst_sum",   64'(sum),  64'(0));
        check_eq("rst_cout",  64'(cout), 64'(0));
        check_eq("rst_ovf",   64'(ovf),  64'(0));
        check_eq("rst_zero",  64'(zero), 64'(0));
        @(posedge clk);
        #1;

        directed("pos_ovf",  16'h7FFF, 16'h0001, 1'b0, sat_pos,  1'b0, 1'b1, 1'b0);
        directed("sub_eq",   16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed("chain",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        directed("neg_ovf",  16'h8000, 16'h0001, 1'b1, sat_neg,  1'b1, 1'b1, 1'b0);
        directed("plain",    16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

        // Back-to-back burst with the consumer stalled for cycles 3..6
        sent = 0; fell = 1'b0; out_base = n_out;
        for (int c = 0; c < 40 && (sent < 8 || c < 16); c++) begin
            out_ready = !(c >= 3 && c <= 6);
            if (sent < 8) begin
                in_valid = 1'b1;
                a   = 16'(16'h1111 * (sent + 1));
                b   = 16'(16'h0203 * (sent + 3));
                sub = 1'(sent);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (!in_ready) fell = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        idle(4);
        check_eq("burst_sent",  64'(sent), 64'(8));
        check_eq("burst_stall", 64'(fell), 64'(1));
        check_eq("burst_count", 64'(n_out - out_base), 64'(8));

        // Reset one cycle after accepting an operand set drops it
        send(16'h0005, 16'h0003, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("mrst_valid", 64'(out_valid), 64'(0));
        check_eq("mrst_sum",   64'(sum),  64'(0));
        check_eq("mrst_cout",  64'(cout), 64'(0));
        check_eq("mrst_ovf",   64'(ovf),  64'(0));
        check_eq("mrst_zero",  64'(zero), 64'(0));
        check_eq("mrst_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        check_eq("mrst_no_out", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        directed("post_rst", 16'h0009, 16'h0004, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0);

        // Random traffic with random backpressure
        acc = 0;
        for (int c = 0; c < 40000 && acc < 10000; c++) begin
            in_valid  = ($urandom % 10) < 7;
            a         = 16'($urandom);
            b         = 16'($urandom);
            sub       = 1'($urandom);
            out_ready = ($urandom % 10) < 7;
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk);
            #1;
        end
        check_eq("rand_count", 64'(acc), 64'(10000));
        in_valid = 1'b0; out_ready = 1'b1;
        idle(5);
        check_eq("drain_empty", 64'(q.size()), 64'(0));
        check_eq("drain_valid", 64'(out_valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
